// File: rtl/scm_arb_pkg.sv
// Shared constants and helpers for the SCM access arbiter.
// Widths default to a 4-requester, 32x64b SCM.
package scm_arb_pkg;

  localparam int SCM_NUM_REQ     = 4;
  localparam int SCM_WADDR_WIDTH = 5;
  localparam int SCM_WDATA_WIDTH = 64;
  localparam int SCM_RDATA_WIDTH = 2 * SCM_WDATA_WIDTH;
  localparam int SCM_RADDR_WIDTH = SCM_WADDR_WIDTH - 1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SCM_ID_WIDTH = id_width(SCM_NUM_REQ);

  // A 128b line holds two 64b words
  function automatic logic [31:0] line_of(input logic [31:0] waddr);
    return waddr >> 1;
  endfunction

endpackage

// File: rtl/scm_rr_arbiter.sv
// Round-robin arbiter with a priority pointer that moves past the winner.
// The pointer only moves when the caller reports the grant as taken.
module scm_rr_arbiter
  import scm_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] ptr;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  hi_req;
  logic [N-1:0]  pick_vec;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (IW'(i) >= ptr);
    end
  end

  // Requests at or above the pointer win first, else wrap to the lowest
  assign hi_req   = req & hi_mask;
  assign pick_vec = (|hi_req) ? hi_req : req;
  assign valid    = |req;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick_vec[i]) idx = IW'(i);
    end
  end

  always_comb begin
    gnt = '0;
    if (valid) gnt[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && valid) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/scm_access_arbiter.sv
// Shares one SCM (64b write, 128b read) between NUM_REQ requesters.
// One write and one read per cycle; same-line reads are held off.
module scm_access_arbiter
  import scm_arb_pkg::*;
#(
  parameter int NUM_REQ     = SCM_NUM_REQ,
  parameter int WADDR_WIDTH = SCM_WADDR_WIDTH,
  parameter int WDATA_WIDTH = SCM_WDATA_WIDTH,
  parameter int RDATA_WIDTH = 2 * WDATA_WIDTH,
  parameter int RADDR_WIDTH = WADDR_WIDTH - 1,
  parameter int ID_WIDTH    = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             we_i,
  input  logic [NUM_REQ*WADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*WDATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic                           rvalid_o,
  output logic [ID_WIDTH-1:0]            rid_o,
  output logic [RDATA_WIDTH-1:0]         rdata_o,
  output logic                           scm_re_o,
  output logic [RADDR_WIDTH-1:0]         scm_raddr_o,
  output logic                           scm_we_o,
  output logic [WADDR_WIDTH-1:0]         scm_waddr_o,
  output logic [WDATA_WIDTH-1:0]         scm_wdata_o,
  input  logic [RDATA_WIDTH-1:0]         scm_rdata_i
);

  logic [NUM_REQ-1:0]     w_cand;
  logic [NUM_REQ-1:0]     r_cand;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [ID_WIDTH-1:0]    w_idx;
  logic [ID_WIDTH-1:0]    r_idx;
  logic                   w_valid;
  logic                   r_valid;
  logic [WADDR_WIDTH-1:0] w_addr;
  logic [WADDR_WIDTH-1:0] r_addr;
  logic [31:0]            w_line;
  logic [31:0]            r_line;
  logic                   hazard;
  logic                   r_fire;
  logic                   rvalid_q;
  logic [ID_WIDTH-1:0]    rid_q;

  assign w_cand = rst ? '0 : (req_i & we_i);
  assign r_cand = rst ? '0 : (req_i & ~we_i);

  scm_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_w_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (w_cand),
    .adv   (w_valid),
    .gnt   (w_gnt),
    .idx   (w_idx),
    .valid (w_valid)
  );

  scm_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_r_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (r_cand),
    .adv   (r_fire),
    .gnt   (r_gnt),
    .idx   (r_idx),
    .valid (r_valid)
  );

  assign w_addr = addr_i[w_idx*WADDR_WIDTH +: WADDR_WIDTH];
  assign r_addr = addr_i[r_idx*WADDR_WIDTH +: WADDR_WIDTH];
  assign w_line = line_of(32'(w_addr));
  assign r_line = line_of(32'(r_addr));

  // The write wins a same-line clash; the reader retries next cycle
  assign hazard = w_valid & r_valid & (w_line == r_line);
  assign r_fire = r_valid & ~hazard;

  assign gnt_o = w_gnt | (r_fire ? r_gnt : '0);

  assign scm_we_o    = w_valid;
  assign scm_waddr_o = w_addr;
  assign scm_wdata_o = wdata_i[w_idx*WDATA_WIDTH +: WDATA_WIDTH];

  assign scm_re_o    = r_fire;
  assign scm_raddr_o = r_line[RADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= r_fire;
      if (r_fire) rid_q <= r_idx;
    end
  end

  // Masking with rst drops a response whose grant preceded reset
  assign rvalid_o = rvalid_q & ~rst;
  assign rid_o    = rid_q;
  assign rdata_o  = scm_rdata_i;

endmodule

// File: tb/tb_scm_access_arbiter.sv
// Bench for scm_access_arbiter: directed steps then random traffic,
// checked against a queue-free reference model and a behavioural SCM.
module tb_scm_access_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int RW = 128;
  localparam int LW = 4;
  localparam int IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic            rvalid;
  logic [IW-1:0]   rid;
  logic [RW-1:0]   rdata;
  logic            scm_re;
  logic [LW-1:0]   scm_raddr;
  logic            scm_we;
  logic [AW-1:0]   scm_waddr;
  logic [DW-1:0]   scm_wdata;
  logic [RW-1:0]   scm_rdata;

  scm_access_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rid_o       (rid),
    .rdata_o     (rdata),
    .scm_re_o    (scm_re),
    .scm_raddr_o (scm_raddr),
    .scm_we_o    (scm_we),
    .scm_waddr_o (scm_waddr),
    .scm_wdata_o (scm_wdata),
    .scm_rdata_i (scm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SCM: address and data captured at the edge
  logic [DW-1:0] scm_mem [32];
  logic [LW-1:0] scm_raddr_q;

  always @(posedge clk) begin
    if (scm_we) scm_mem[scm_waddr] <= scm_wdata;
    if (scm_re) scm_raddr_q <= scm_raddr;
  end

  assign scm_rdata = {scm_mem[{scm_raddr_q, 1'b1}],
                      scm_mem[{scm_raddr_q, 1'b0}]};

  // Reference model state
  logic [DW-1:0] mm [32];
  int wptr, rptr, pend_line, exp_rid;
  bit pend;
  int n_pass, n_tot;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] c, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (c[j]) return j;
    end
    return -1;
  endfunction

  task automatic idle();
    req = '0;
    we  = '0;
  endtask

  task automatic put(input int i, input bit w, input int a,
                     input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = AW'(a);
    wdata[i*DW +: DW] = d;
  endtask

  task automatic step(input string tg);
    int ww, rw, wa, ra;
    bit hz;
    logic [N-1:0] eg;
    #1;
    ww = rst ? -1 : pick(req & we, wptr);
    rw = rst ? -1 : pick(req & ~we, rptr);
    wa = (ww >= 0) ? int'(addr[ww*AW +: AW]) : 0;
    ra = (rw >= 0) ? int'(addr[rw*AW +: AW]) : 0;
    hz = (ww >= 0) && (rw >= 0) && ((wa >> 1) == (ra >> 1));
    if (hz) rw = -1;
    eg = '0;
    if (ww >= 0) eg[ww] = 1'b1;
    if (rw >= 0) eg[rw] = 1'b1;
    chk({tg, ".gnt"}, 128'(gnt), 128'(eg));
    chk({tg, ".we"}, 128'(scm_we), 128'(ww >= 0));
    if (ww >= 0) begin
      chk({tg, ".waddr"}, 128'(scm_waddr), 128'(wa));
      chk({tg, ".wdata"}, 128'(scm_wdata), 128'(wdata[ww*DW +: DW]));
    end
    chk({tg, ".re"}, 128'(scm_re), 128'(rw >= 0));
    if (rw >= 0) chk({tg, ".raddr"}, 128'(scm_raddr), 128'(ra >> 1));
    chk({tg, ".rvalid"}, 128'(rvalid), 128'(pend && !rst));
    chk({tg, ".rid"}, 128'(rid), 128'(exp_rid));
    if (pend && !rst)
      chk({tg, ".rdata"}, rdata, {mm[2*pend_line+1], mm[2*pend_line]});
    @(posedge clk);
    if (rst) begin
      wptr = 0; rptr = 0; pend = 0; exp_rid = 0;
    end else begin
      if (ww >= 0) begin
        mm[wa] = wdata[ww*DW +: DW];
        wptr = (ww + 1) % N;
      end
      if (rw >= 0) begin
        rptr = (rw + 1) % N;
        pend = 1;
        pend_line = ra >> 1;
        exp_rid = rw;
      end else begin
        pend = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step("rst");
    rst = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_tot = 0;
    wptr = 0; rptr = 0; pend = 0; exp_rid = 0; pend_line = 0;
    rst = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    @(posedge clk);
    @(negedge clk);
    step("reset");
    rst = 1'b0;

    // Populate every word so reads compare against known data
    for (int i = 0; i < 32; i++) begin
      idle();
      put(2, 1'b1, i, {$urandom, $urandom});
      step("fill");
    end

    // Single read of line 3
    do_reset();
    idle();
    put(0, 1'b0, 6, '0);
    #1;
    chk("rd1.gnt_c", 128'(gnt), 128'(4'b0001));
    chk("rd1.raddr_c", 128'(scm_raddr), 128'(3));
    step("rd1");
    idle();
    #1;
    chk("rd1.rid_c", 128'(rid), 128'(0));
    step("rd1r");

    // Round robin over four readers from a fresh pointer
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      for (int i = 0; i < N; i++) put(i, 1'b0, (c * 8 + i * 2) % 32, '0);
      #1;
      chk("rr.order", 128'(gnt), 128'(4'b0001 << (c % N)));
      step("rr");
    end
    idle();
    step("rr_tail");

    // Concurrent write and read to different lines
    idle();
    put(0, 1'b1, 4, 64'h0123_4567_89AB_CDEF);
    put(1, 1'b0, 10, '0);
    step("conc");
    idle();
    step("conc_tail");

    // Same-line hazard: write wins, read follows next cycle
    idle();
    put(0, 1'b1, 9, 64'hDEAD);
    put(1, 1'b0, 8, '0);
    #1;
    chk("hz.gnt_c", 128'(gnt), 128'(4'b0001));
    chk("hz.re_c", 128'(scm_re), 128'(0));
    step("hz");
    idle();
    put(1, 1'b0, 8, '0);
    step("hz2");
    chk("hz.hi", 128'(rdata[127:64]), 128'(64'hDEAD));
    chk("hz.rid", 128'(rid), 128'(1));
    chk("hz.rvalid", 128'(rvalid), 128'(1));
    idle();
    step("hz_tail");

    // Reset right after a read grant swallows its response
    idle();
    put(2, 1'b0, 12, '0);
    step("rm");
    rst = 1'b1;
    idle();
    for (int i = 0; i < N; i++) put(i, 1'b0, 2 * i, '0);
    #1;
    chk("rm.rvalid_c", 128'(rvalid), 128'(0));
    step("rm_rst");
    rst = 1'b0;
    #1;
    chk("rm.first", 128'(gnt), 128'(4'b0001));
    step("rm_after");

    // Write pointer wrap from 3 back to 0
    do_reset();
    for (int c = 0; c < 2; c++) begin
      idle();
      put(3, 1'b1, 20 + c, {$urandom, $urandom});
      step("wrap3");
    end
    idle();
    put(0, 1'b1, 24, {$urandom, $urandom});
    put(3, 1'b1, 26, {$urandom, $urandom});
    #1;
    chk("wrap.gnt_c", 128'(gnt), 128'(4'b0001));
    step("wrap");

    // Random traffic with a narrow address range to provoke hazards
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = N'($urandom);
      we  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW] = (c % 2 == 0) ? AW'($urandom_range(0, 5))
                                        : AW'($urandom);
        wdata[i*DW +: DW] = {$urandom, $urandom};
      end
      step("rnd");
    end
    rst = 1'b0;
    idle();
    step("end");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/scm_access_arbiter.md
Name: scm_access_arbiter

Overview:
- Shares one latch-SCM instance (1 write port of 64b, 1 read port of 128b) between NUM_REQ requesters, e.g. accelerator lanes and a DMA.
- Each cycle it grants at most one write and at most one read through two independent round-robin arbiters.
- It blocks a read that targets the line being written in the same cycle, and returns read data with the requester ID.
- Sits directly in front of the SCM and drives its ReadEnable/ReadAddr/WriteEnable/WriteAddr/WriteData.

Parameters:
- NUM_REQ, 4, number of requesters (power of two not required, >=2).
- WADDR_WIDTH, 5, SCM word address width (64b words).
- WDATA_WIDTH, 64, write word width.
- RDATA_WIDTH, 128, read line width; must be 2*WDATA_WIDTH.
- RADDR_WIDTH, WADDR_WIDTH-1, line address width (derived, do not override).
- ID_WIDTH, max(1,$clog2(NUM_REQ)), requester index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request.
- we_i  in  NUM_REQ  1=write, 0=read.
- addr_i  in  NUM_REQ*WADDR_WIDTH  word address; reads use bits [WADDR_WIDTH-1:1] as line index.
- wdata_i  in  NUM_REQ*WDATA_WIDTH  write data.
- gnt_o  out  NUM_REQ  grant; request is accepted in the cycle req&gnt.
- rvalid_o  out  1  read data valid.
- rid_o  out  ID_WIDTH  requester that owns rdata_o.
- rdata_o  out  RDATA_WIDTH  read line, passed through from scm_rdata_i.
- scm_re_o  out  1  SCM ReadEnable.
- scm_raddr_o  out  RADDR_WIDTH  SCM ReadAddr.
- scm_we_o  out  1  SCM WriteEnable.
- scm_waddr_o  out  WADDR_WIDTH  SCM WriteAddr.
- scm_wdata_o  out  WDATA_WIDTH  SCM WriteData.
- scm_rdata_i  in  RDATA_WIDTH  SCM ReadData.

Behaviour:
- Arbitration:
  - Write candidates are req_i&we_i; read candidates are req_i&~we_i.
  - Each set has its own round-robin arbiter with a priority pointer. The pointer resets to index 0.
  - After a grant, the pointer moves to winner+1, wrapping at NUM_REQ-1 -> 0. The pointer is unchanged when nothing is granted.
  - Arbitration is combinational. gnt_o is combinational from req_i/we_i/addr_i and the pointers.
  - At most one write grant and one read grant per cycle. A requester has one request per cycle, so it can never get both.
- SCM drive:
  - scm_we_o, scm_waddr_o and scm_wdata_o come combinationally from the write winner.
  - scm_re_o and scm_raddr_o come combinationally from the read winner.
  - The SCM samples WriteData and the read address at the next clk edge.
  - A write is committed in the SCM during the first half of the following cycle.
- Same-line hazard:
  - Applies when the read winner's line equals the write winner's addr>>1 in the same cycle.
  - The read is not granted. scm_re_o=0, and the read pointer does not advance.
  - The write proceeds. The read requester must hold its request and wins the next cycle at the earliest.
  - A read to that line in the next cycle is legal and returns the new data.
- Read response:
  - Latency is exactly 1 cycle. rvalid_o=1 in cycle t+1 for a read granted in cycle t.
  - rid_o is registered from the winner's index in cycle t. rdata_o=scm_rdata_i.
  - rvalid_o is a single-cycle pulse per grant, and back-to-back reads give consecutive pulses.
  - rid_o holds its last value when rvalid_o=0.
- Reset:
  - rvalid_o=0, rid_o=0, both pointers=0.
  - Combinational outputs follow the inputs. While rst=1, gnt_o=0, scm_re_o=0 and scm_we_o=0.
  - A read granted in the cycle before reset asserts produces no rvalid_o.
  - SCM contents are not reset.
- Boundaries:
  - Line NUM_R_WORDS-1 is the highest legal read line.
  - The pointer wraps from NUM_REQ-1 to 0.
  - req_i dropped without a grant is legal; no state is kept for it.

Decomposition:
- Package scm_arb_pkg holds:
  - the derived width constants (RADDR_WIDTH, ID_WIDTH);
  - the function line_of(waddr) = waddr>>1.
- Sub-module scm_rr_arbiter (parameter N):
  - inputs: req vector and an advance enable;
  - outputs: one-hot gnt, winner index, valid;
  - pointer register with synchronous active-high reset;
  - instantiated twice, once for writes and once for reads.

Test Plan:
- Single read: after reset, req_i=0001, we=0, addr=6 -> gnt=0001, scm_raddr=3; next cycle rvalid=1, rid=0, rdata equals the line written earlier.
- Round-robin: req_i=1111 reads held for 5 cycles, distinct addresses -> grants 0,1,2,3,0 in order; rvalid/rid follow one cycle later.
- Concurrent read and write: req0 write addr 4 data A, req1 read addr 10, same cycle -> both granted; scm_we=1, scm_re=1, scm_raddr=5.
- Hazard: req0 write addr 9 data 0xDEAD, req1 read addr 8, same cycle:
  - -> write granted, read not granted.
  - Next cycle the read is granted. The cycle after, rdata[127:64]=0xDEAD and rid=1.
- Reset mid-operation: read granted, rst=1 the next cycle -> rvalid=0; after release the first read grant goes to requester 0 when all requesters request.
- Pointer wrap: NUM_REQ=4, only req3 writing for 2 cycles, then req0 and req3 writing -> req0 wins (pointer is at 0 after the grant to 3).
